// File: rtl/sargantana_icache_repl_unit.sv
// Per-set way-replacement state for the icache: age-LRU, tree-PLRU or LFSR random,
// invalid-first victim selection and a one-set-per-cycle sequenced flush.
module sargantana_icache_repl_unit #(
  parameter int unsigned P_NWAYS  = 4,
  parameter int unsigned P_NSETS  = 64,
  parameter int unsigned P_POLICY = 0
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       hit_i,
  input  logic [$clog2(P_NSETS)-1:0] hit_set_i,
  input  logic [$clog2(P_NWAYS)-1:0] hit_way_i,
  input  logic                       fill_i,
  input  logic [$clog2(P_NSETS)-1:0] fill_set_i,
  input  logic [$clog2(P_NWAYS)-1:0] fill_way_i,
  input  logic [$clog2(P_NSETS)-1:0] vict_set_i,
  input  logic [P_NWAYS-1:0]         way_valid_i,
  output logic [$clog2(P_NWAYS)-1:0] victim_way_o,
  output logic                       busy_o
);

  localparam int unsigned W  = $clog2(P_NWAYS);
  localparam int unsigned S  = $clog2(P_NSETS);
  localparam int unsigned NN = P_NWAYS - 1;

  typedef logic [P_NWAYS-1:0][W-1:0] ages_t;
  typedef logic [NN-1:0]             tree_t;
  typedef enum logic [0:0] {IDLE, FLUSH} state_e;

  state_e         state_q, state_d;
  logic [S-1:0]   cnt_q, cnt_d;
  logic [15:0]    lfsr_q;
  logic           flush_wr, hit_acc, fill_acc;
  logic [W-1:0]   pol_vict, inv_way;

  function automatic ages_t age_init();
    ages_t r;
    for (int w = 0; w < int'(P_NWAYS); w++) r[w] = W'(w);
    return r;
  endfunction

  // Promoted way becomes youngest; only ways younger than it age by one.
  function automatic ages_t age_promote(ages_t a, logic [W-1:0] u);
    ages_t r;
    r = a;
    for (int w = 0; w < int'(P_NWAYS); w++) begin
      if (W'(w) == u)     r[w] = '0;
      else if (a[w] < a[u]) r[w] = a[w] + W'(1);
    end
    return r;
  endfunction

  function automatic tree_t plru_promote(tree_t t, logic [W-1:0] u);
    tree_t        r;
    logic [W-1:0] n;
    r = t;
    n = '0;
    for (int l = int'(W) - 1; l >= 0; l--) begin
      r[n] = ~u[l];
      n    = W'(2 * 32'(n) + 32'd1 + 32'(u[l]));
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == S'(P_NSETS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + S'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Events are accepted only in IDLE with no flush starting; fill wins a same-set collision.
  always_comb begin
    busy_o   = (state_q == FLUSH);
    flush_wr = (state_q == FLUSH);
    fill_acc = fill_i && (state_q == IDLE) && !flush_i;
    hit_acc  = hit_i && (state_q == IDLE) && !flush_i && !(fill_acc && (fill_set_i == hit_set_i));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       lfsr_q <= 16'hACE1;
    else if (fill_acc) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  generate
    if (P_POLICY == 0) begin : g_age
      ages_t age_q [P_NSETS];

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          for (int s = 0; s < int'(P_NSETS); s++) age_q[s] <= age_init();
        end else begin
          for (int s = 0; s < int'(P_NSETS); s++) begin
            if (flush_wr && cnt_q == S'(s))          age_q[s] <= age_init();
            else if (fill_acc && fill_set_i == S'(s)) age_q[s] <= age_promote(age_q[s], fill_way_i);
            else if (hit_acc && hit_set_i == S'(s))   age_q[s] <= age_promote(age_q[s], hit_way_i);
          end
        end
      end

      always_comb begin
        pol_vict = '0;
        for (int w = 0; w < int'(P_NWAYS); w++)
          if (age_q[vict_set_i][w] == W'(P_NWAYS - 1)) pol_vict = W'(w);
      end
    end else if (P_POLICY == 1) begin : g_plru
      tree_t tree_q [P_NSETS];

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          for (int s = 0; s < int'(P_NSETS); s++) tree_q[s] <= '0;
        end else begin
          for (int s = 0; s < int'(P_NSETS); s++) begin
            if (flush_wr && cnt_q == S'(s))          tree_q[s] <= '0;
            else if (fill_acc && fill_set_i == S'(s)) tree_q[s] <= plru_promote(tree_q[s], fill_way_i);
            else if (hit_acc && hit_set_i == S'(s))   tree_q[s] <= plru_promote(tree_q[s], hit_way_i);
          end
        end
      end

      // Root-to-leaf walk; each node bit selects the half holding the victim.
      always_comb begin
        logic [W-1:0] n;
        logic         b;
        pol_vict = '0;
        n        = '0;
        for (int l = int'(W) - 1; l >= 0; l--) begin
          b           = tree_q[vict_set_i][n];
          pol_vict[l] = b;
          n           = W'(2 * 32'(n) + 32'd1 + 32'(b));
        end
      end
    end else begin : g_rnd
      always_comb pol_vict = lfsr_q[W-1:0];
    end
  endgenerate

  always_comb begin
    inv_way = '0;
    for (int w = int'(P_NWAYS) - 1; w >= 0; w--)
      if (!way_valid_i[w]) inv_way = W'(w);
  end

  assign victim_way_o = (&way_valid_i) ? pol_vict : inv_way;

endmodule
